// File: rtl/ej32_mb8_mem.sv
// eJ32 8-bit bus memory responder: dual-port byte SRAM, TIB rx ring writer,
// and an OBUF-window tx FIFO that streams core console output to the host.
module ej32_mb8_mem #(
    parameter int unsigned TIB  = 'h1000,
    parameter int unsigned IBSZ = 'h400,
    parameter int unsigned OBUF = 'h1400,
    parameter int unsigned OBSZ = 'h400,
    parameter int unsigned TXD  = 16,
    parameter int unsigned ASZ  = 17
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [ASZ-1:0] ai,
    input  logic           we,
    input  logic [7:0]     vi,
    output logic [7:0]     vo,
    input  logic           rx_valid,
    input  logic [7:0]     rx_data,
    output logic           rx_ready,
    output logic [ASZ-1:0] rx_ptr,
    output logic           tx_valid,
    output logic [7:0]     tx_data,
    input  logic           tx_ready,
    output logic           tx_ovf
);

    localparam int unsigned IBW = $clog2(IBSZ);
    localparam int unsigned TXW = $clog2(TXD);
    localparam int unsigned CW  = TXW + 1;
    localparam int unsigned MSZ = 2 ** ASZ;

    logic [7:0]     mem  [MSZ];
    logic [7:0]     fifo [TXD];
    logic [TXW-1:0] wr_ptr;
    logic [TXW-1:0] rd_ptr;
    logic [CW-1:0]  count;

    logic           obuf_hit;
    logic           full;
    logic           pop;
    logic           push;
    logic           drop;
    logic           rx_fire;
    logic [CW-1:0]  count_nxt;
    logic [CW-1:0]  left;
    logic [TXW-1:0] rd_nxt;
    logic [7:0]     head_nxt;
    logic [ASZ-1:0] rx_ptr_nxt;

    // Transfer decode; a pop in the same cycle frees a slot for a push into a full FIFO
    always_comb begin
        obuf_hit   = (32'(ai) >= OBUF) && (32'(ai) < OBUF + OBSZ);
        full       = (count == CW'(TXD));
        pop        = tx_valid && tx_ready;
        push       = we && obuf_hit && (!full || pop);
        drop       = we && obuf_hit && full && !pop;
        rx_fire    = rx_valid && rx_ready;
        count_nxt  = count + CW'(push) - CW'(pop);
        left       = count - CW'(pop);
        rd_nxt     = rd_ptr + TXW'(pop);
        head_nxt   = fifo[rd_nxt];
        if (left == '0) begin
            head_nxt = vi;
        end
        rx_ptr_nxt = {rx_ptr[ASZ-1:IBW], rx_ptr[IBW-1:0] + IBW'(1)};
    end

    // Storage: host port written first so a same-address core write wins
    always_ff @(posedge clk) begin
        if (rx_fire) begin
            mem[rx_ptr] <= rx_data;
        end
        if (we) begin
            mem[ai] <= vi;
        end
        if (push) begin
            fifo[wr_ptr] <= vi;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vo       <= '0;
            rx_ptr   <= ASZ'(TIB);
            rx_ready <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            tx_ovf   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            vo       <= mem[ai];
            rx_ready <= 1'b1;
            if (rx_fire) begin
                rx_ptr <= rx_ptr_nxt;
            end
            if (drop) begin
                tx_ovf <= 1'b1;
            end
            wr_ptr   <= wr_ptr + TXW'(push);
            rd_ptr   <= rd_nxt;
            count    <= count_nxt;
            tx_valid <= (count_nxt != '0);
            // Head byte is registered: bypass vi when the FIFO would otherwise be empty
            if (count_nxt != '0) begin
                tx_data <= head_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ej32_mb8_mem.sv
// Bench for ej32_mb8_mem: directed stimulus with expected read and tx bytes
// queued at issue time and popped by an independent output monitor.
module tb_ej32_mb8_mem;

    localparam int unsigned ASZ = 17;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [ASZ-1:0] ai = '0;
    logic           we = 1'b0;
    logic [7:0]     vi = '0;
    logic [7:0]     vo;
    logic           rx_valid = 1'b0;
    logic [7:0]     rx_data = '0;
    logic           rx_ready;
    logic [ASZ-1:0] rx_ptr;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           tx_ready = 1'b0;
    logic           tx_ovf;

    int total = 0;
    int bad = 0;

    logic [7:0] rd_q[$];
    logic [7:0] tx_q[$];
    logic       chk_rd = 1'b0;
    logic       rd_pend = 1'b0;
    logic [7:0] e_rd;
    logic [7:0] e_tx;

    ej32_mb8_mem dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ai       (ai),
        .we       (we),
        .vi       (vi),
        .vo       (vo),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .rx_ptr   (rx_ptr),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx_ovf   (tx_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Read data is due one edge after the address was presented
    always @(posedge clk) rd_pend <= chk_rd;

    // Monitor: pops expectations whenever the DUT presents read data or a tx transfer
    always begin
        @(negedge clk);
        #1;
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: got %0h expected nothing", vo);
            end else begin
                e_rd = rd_q.pop_front();
                check("rd_vo", 32'(vo), 32'(e_rd));
            end
        end
        if (rst_n && tx_valid && tx_ready) begin
            if (tx_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL tx_unexpected: got %0h expected nothing", tx_data);
            end else begin
                e_tx = tx_q.pop_front();
                check("tx_data", 32'(tx_data), 32'(e_tx));
            end
        end
    end

    task automatic idle();
        @(negedge clk);
        we = 1'b0;
        chk_rd = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic wr(input logic [ASZ-1:0] a, input logic [7:0] d,
                      input logic chk, input logic [7:0] old);
        @(negedge clk);
        ai = a;
        we = 1'b1;
        vi = d;
        rx_valid = 1'b0;
        chk_rd = chk;
        if (chk) rd_q.push_back(old);
    endtask

    task automatic rd(input logic [ASZ-1:0] a, input logic [7:0] exp);
        @(negedge clk);
        ai = a;
        we = 1'b0;
        rx_valid = 1'b0;
        chk_rd = 1'b1;
        rd_q.push_back(exp);
    endtask

    function automatic logic [7:0] rxb(input int i);
        return 8'(i) + ((i >= 1024) ? 8'h80 : 8'h00);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_vo", 32'(vo), 0);
        check("rst_rx_ptr", 32'(rx_ptr), 'h1000);
        check("rst_rx_ready", 32'(rx_ready), 0);
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_tx_ovf", 32'(tx_ovf), 0);
        rst_n = 1'b1;
        idle();
        check("rx_ready_up", 32'(rx_ready), 1);

        // Read latency, read-before-write, back-to-back reads
        wr('h0040, 8'hA5, 1'b0, 8'h00);
        rd('h0040, 8'hA5);
        wr('h0100, 8'h11, 1'b0, 8'h00);
        wr('h0100, 8'h3C, 1'b1, 8'h11);
        rd('h0100, 8'h3C);
        rd('h0040, 8'hA5);
        rd('h0100, 8'h3C);
        idle();

        // OBUF window edges must not enqueue; then stream with backpressure
        tx_ready = 1'b0;
        wr('h13FF, 8'h99, 1'b0, 8'h00);
        wr('h1800, 8'h98, 1'b0, 8'h00);
        idle();
        check("obuf_edge_no_push", 32'(tx_valid), 0);
        wr('h1400, 8'h41, 1'b0, 8'h00); tx_q.push_back(8'h41);
        wr('h1401, 8'h42, 1'b0, 8'h00); tx_q.push_back(8'h42);
        check("tx_valid_first", 32'(tx_valid), 1);
        check("tx_head_first", 32'(tx_data), 'h41);
        wr('h1402, 8'h43, 1'b0, 8'h00); tx_q.push_back(8'h43);
        idle();
        idle();
        check("tx_head_held", 32'(tx_data), 'h41);
        tx_ready = 1'b1;
        repeat (3) idle();
        check("tx_drained", 32'(tx_valid), 0);
        tx_ready = 1'b0;

        // Fill to 16, 17th accepted via simultaneous pop, 18th dropped
        for (int i = 0; i < 16; i++) begin
            wr(ASZ'('h1400 + i), 8'(8'h10 + i), 1'b0, 8'h00);
            tx_q.push_back(8'(8'h10 + i));
        end
        idle();
        check("ovf_after_16", 32'(tx_ovf), 0);
        wr('h1410, 8'h20, 1'b0, 8'h00);
        tx_ready = 1'b1;
        tx_q.push_back(8'h20);
        wr('h1411, 8'h21, 1'b0, 8'h00);
        tx_ready = 1'b0;
        check("ovf_push_with_pop", 32'(tx_ovf), 0);
        idle();
        check("ovf_dropped", 32'(tx_ovf), 1);
        tx_ready = 1'b1;
        repeat (17) idle();
        check("full_drained", 32'(tx_valid), 0);
        check("ovf_sticky", 32'(tx_ovf), 1);
        tx_ready = 1'b0;

        // rx ring: IBSZ+2 bytes, wrap at the end of the ring
        for (int i = 0; i < 1026; i++) begin
            @(negedge clk);
            if (i == 1023) check("rx_ptr_top", 32'(rx_ptr), 'h13FF);
            if (i == 1024) check("rx_ptr_wrap", 32'(rx_ptr), 'h1000);
            we = 1'b0;
            chk_rd = 1'b0;
            rx_valid = 1'b1;
            rx_data = rxb(i);
        end
        idle();
        check("rx_ptr_after", 32'(rx_ptr), 'h1002);
        rd('h1000, 8'h80);
        rd('h1001, 8'h81);
        rd('h1005, 8'h05);
        rd('h13FF, 8'hFF);

        // Same-address core and rx write: core data wins, pointer still advances
        @(negedge clk);
        ai = 'h1002; we = 1'b1; vi = 8'hEE; chk_rd = 1'b0;
        rx_valid = 1'b1; rx_data = 8'h77;
        @(negedge clk);
        check("rx_ptr_collide", 32'(rx_ptr), 'h1003);
        ai = 'h1003; we = 1'b0; chk_rd = 1'b1; rd_q.push_back(8'h03);
        rx_valid = 1'b1; rx_data = 8'h66;
        idle();
        rd('h1002, 8'hEE);
        rd('h1003, 8'h66);
        idle();

        // Async reset with 5 bytes queued and vo non-zero
        for (int i = 0; i < 5; i++) wr(ASZ'('h1420 + i), 8'(8'hC0 + i), 1'b0, 8'h00);
        rd('h0040, 8'hA5);
        idle();
        check("pre_rst_tx_valid", 32'(tx_valid), 1);
        check("pre_rst_ovf", 32'(tx_ovf), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_tx_valid", 32'(tx_valid), 0);
        check("arst_vo", 32'(vo), 0);
        check("arst_ovf", 32'(tx_ovf), 0);
        check("arst_rx_ptr", 32'(rx_ptr), 'h1000);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        tx_ready = 1'b1;
        idle();
        check("post_rst_fifo_empty", 32'(tx_valid), 0);
        rd('h0100, 8'h3C);
        rd('h1002, 8'hEE);
        rd('h0040, 8'hA5);
        idle();
        idle();

        check("rd_q_drained", 32'(rd_q.size()), 0);
        check("tx_q_drained", 32'(tx_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
